// File: rtl/whizgraphics_if.sv
// Byte-wide peripheral bus shared by the gateboy blocks; the peripheral
// side answers reads with a registered rdata.
interface DataBus;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        we;
  logic        re;

  modport peripheral (input addr, input wdata, input we, input re, output rdata);
  modport host (output addr, output wdata, output we, output re, input rdata);
endinterface

// File: rtl/whizgraphics.sv
// Background-layer scanline renderer: tile patterns, 32x32 map, scroll and
// palette registers on the bus; renders one 160-pixel line per drawline.
module whizgraphics #(
  parameter int NUM_TILES = 384,
  parameter int LCD_W     = 160,
  parameter int LCD_H     = 144
) (
  input  logic       clk,
  input  logic       reset_n,
  DataBus.peripheral db,
  input  logic       drawline,
  output logic       renderComplete,
  output logic [1:0] lcd [LCD_H][LCD_W]
);

  localparam int          TILE_BYTES = NUM_TILES * 16;
  localparam logic [15:0] TILE_BASE  = 16'h8000;
  localparam logic [15:0] TILE_END   = TILE_BASE + 16'(TILE_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  logic [7:0] tile_mem [TILE_BYTES];
  logic [7:0] map_mem  [1024];

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d, y_q, y_d, line_q, line_d;
  logic       rc_q, rc_d;
  logic [7:0] scx_q, scy_q, bgp_q, rdata_q;

  logic        tile_sel_s, map_sel_s, pix_we_s;
  logic [12:0] tile_off_s, row_base_s;
  logic [7:0]  rd_s, bx_s, by_s, tile_idx_s, lo_s, hi_s;
  logic [2:0]  col_s;
  logic [1:0]  pix_s, shade_s;

  assign tile_sel_s = (db.addr >= TILE_BASE) && (db.addr < TILE_END);
  assign map_sel_s  = (db.addr[15:10] == 6'b100110);
  assign tile_off_s = 13'(db.addr - TILE_BASE);

  // Pixel fetch reads live memory/registers, so bus writes apply to the next pixel.
  assign bx_s       = x_q + scx_q;
  assign by_s       = y_q + scy_q;
  assign tile_idx_s = map_mem[{by_s[7:3], bx_s[7:3]}];
  assign row_base_s = {1'b0, tile_idx_s, by_s[2:0], 1'b0};
  assign lo_s       = tile_mem[row_base_s];
  assign hi_s       = tile_mem[row_base_s | 13'd1];
  assign col_s      = 3'd7 - bx_s[2:0];
  assign pix_s      = {hi_s[col_s], lo_s[col_s]};
  assign shade_s    = bgp_q[{pix_s, 1'b0} +: 2];

  always_comb begin
    rd_s = 8'hFF;
    if (tile_sel_s) begin
      rd_s = tile_mem[tile_off_s];
    end else if (map_sel_s) begin
      rd_s = map_mem[db.addr[9:0]];
    end else begin
      case (db.addr)
        16'hFF42: rd_s = scy_q;
        16'hFF43: rd_s = scx_q;
        16'hFF47: rd_s = bgp_q;
        default:  rd_s = 8'hFF;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    line_d   = line_q;
    rc_d     = rc_q;
    pix_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (drawline) begin
          state_d = S_DRAW;
          y_d     = line_q;
          x_d     = 8'd0;
          rc_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAW: begin
        pix_we_s = 1'b1;
        if (x_q == 8'(LCD_W - 1)) begin
          state_d = S_DONE;
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (y_q == 8'(LCD_H - 1)) begin
          rc_d   = 1'b1;
          line_d = 8'd0;
        end else begin
          line_d = y_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      line_q  <= 8'd0;
      rc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      line_q  <= line_d;
      rc_q    <= rc_d;
    end
  end

  // Registers and read data: a same-cycle read returns the pre-write value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scy_q   <= 8'h00;
      scx_q   <= 8'h00;
      bgp_q   <= 8'hE4;
      rdata_q <= 8'hFF;
    end else begin
      if (db.we && db.addr == 16'hFF42) scy_q <= db.wdata;
      else                              scy_q <= scy_q;
      if (db.we && db.addr == 16'hFF43) scx_q <= db.wdata;
      else                              scx_q <= scx_q;
      if (db.we && db.addr == 16'hFF47) bgp_q <= db.wdata;
      else                              bgp_q <= bgp_q;
      if (db.re) rdata_q <= rd_s;
      else       rdata_q <= rdata_q;
    end
  end

  // Tile and map storage survive reset.
  always_ff @(posedge clk) begin
    if (db.we && tile_sel_s) tile_mem[tile_off_s] <= db.wdata;
    if (db.we && map_sel_s)  map_mem[db.addr[9:0]] <= db.wdata;
  end

  // Frame buffer keeps its contents across reset; a reset cycle writes nothing.
  always_ff @(posedge clk) begin
    if (reset_n && pix_we_s) lcd[y_q][x_q] <= shade_s;
  end

  assign db.rdata       = rdata_q;
  assign renderComplete = rc_q;

endmodule

// File: tb/tb_whizgraphics.sv
// Directed and randomized bench for whizgraphics against a per-pixel
// arithmetic reference of the background renderer.
module tb_whizgraphics;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, drawline, renderComplete;
  logic [1:0] lcd [144][160];
  DataBus bus();

  whizgraphics dut (
    .clk(clk), .reset_n(reset_n), .db(bus), .drawline(drawline),
    .renderComplete(renderComplete), .lcd(lcd)
  );

  logic [7:0] m_tile [6144];
  logic [7:0] m_map  [1024];
  logic [7:0] m_scx, m_scy, m_bgp;
  int         m_line;
  logic       m_rc;
  logic [1:0] exp_lcd [144][160];
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] ref_pixel(input int x, input int y);
    int bx = (x + m_scx) % 256;
    int by = (y + m_scy) % 256;
    int t  = m_map[(by / 8) * 32 + bx / 8];
    int lo = m_tile[t * 16 + (by % 8) * 2];
    int hi = m_tile[t * 16 + (by % 8) * 2 + 1];
    int b  = 7 - (bx % 8);
    int p  = ((hi >> b) & 1) * 2 + ((lo >> b) & 1);
    return 2'((m_bgp >> (2 * p)) & 3);
  endfunction

  function automatic logic [7:0] ref_read(input int a);
    if (a >= 'h8000 && a < 'h9800) return m_tile[a - 'h8000];
    else if (a >= 'h9800 && a < 'h9C00) return m_map[a - 'h9800];
    else if (a == 'hFF42) return m_scy;
    else if (a == 'hFF43) return m_scx;
    else if (a == 'hFF47) return m_bgp;
    else return 8'hFF;
  endfunction

  task automatic model_write(input int a, input logic [7:0] d);
    if (a >= 'h8000 && a < 'h9800) m_tile[a - 'h8000] = d;
    else if (a >= 'h9800 && a < 'h9C00) m_map[a - 'h9800] = d;
    else if (a == 'hFF42) m_scy = d;
    else if (a == 'hFF43) m_scx = d;
    else if (a == 'hFF47) m_bgp = d;
  endtask

  task automatic model_pixels(input int x0, input int x1);
    for (int x = x0; x <= x1; x++) exp_lcd[m_line][x] = ref_pixel(x, m_line);
  endtask

  task automatic model_end_line();
    if (m_line == 143) begin m_rc = 1'b1; m_line = 0; end
    else m_line = m_line + 1;
  endtask

  task automatic model_full_line();
    m_rc = 1'b0;
    model_pixels(0, 159);
    model_end_line();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; drawline = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    m_scx = 8'h00; m_scy = 8'h00; m_bgp = 8'hE4; m_line = 0; m_rc = 1'b0;
  endtask

  task automatic bus_write(input int a, input logic [7:0] d);
    bus.addr = 16'(a); bus.wdata = d; bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input string tag, input int a);
    bus.addr = 16'(a); bus.re = 1'b1;
    tick();
    bus.re = 1'b0;
    check(tag, bus.rdata, ref_read(a));
  endtask

  task automatic render_lines(input int n);
    drawline = 1'b1;
    repeat (n * 162) tick();
    drawline = 1'b0;
    tick();
    repeat (n) model_full_line();
  endtask

  task automatic check_span(input string tag, input int y, input int x0, input int x1);
    int nbad = 0;
    int fx = -1;
    for (int x = x0; x <= x1; x++) begin
      if (lcd[y][x] !== exp_lcd[y][x]) begin
        if (fx < 0) fx = x;
        nbad++;
      end
    end
    n_cmp++;
    assert (nbad === 0) else begin
      n_err++;
      $error("FAIL %s row %0d: %0d pixel(s) differ, first x=%0d observed %0d expected %0d",
             tag, y, nbad, fx, lcd[y][fx], exp_lcd[y][fx]);
    end
  endtask

  task automatic check_rows(input string tag, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) check_span(tag, y, 0, 159);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 6144; i++) m_tile[i] = 8'h00;
    for (int i = 0; i < 1024; i++) m_map[i] = 8'h00;
    bus.addr = 16'h0000; bus.wdata = 8'h00;

    // Reset state
    do_reset();
    check("rst_rc", renderComplete, 1'b0);
    bus_read("rst_scy", 'hFF42);
    bus_read("rst_scx", 'hFF43);
    bus_read("rst_bgp", 'hFF47);
    check("rst_bgp_const", bus.rdata, 8'hE4);

    // Scene setup: blank tiles 0..7, zero map, checkerboard tile 0
    for (int i = 0; i < 128; i++) bus_write('h8000 + i, 8'h00);
    for (int i = 0; i < 1024; i++) bus_write('h9800 + i, 8'h00);
    for (int r = 0; r < 8; r += 2) begin
      bus_write('h8000 + 2 * r, 8'hAA);
      bus_write('h8000 + 2 * r + 1, 8'hAA);
    end

    // Readback, unmapped, and simultaneous write/read
    bus_read("rd_tile0", 'h8000);
    bus_read("rd_map0", 'h9800);
    bus_read("rd_unmapped", 'h0000);
    check("rd_unmapped_const", bus.rdata, 8'hFF);
    bus_write('hFF42, 8'h5A);
    bus_read("rd_scy", 'hFF42);
    check("rd_scy_const", bus.rdata, 8'h5A);
    bus.addr = 16'hFF43; bus.wdata = 8'h33; bus.we = 1'b1; bus.re = 1'b1;
    tick();
    bus.we = 1'b0; bus.re = 1'b0;
    check("we_re_old", bus.rdata, ref_read('hFF43));
    model_write('hFF43, 8'h33);
    bus_read("we_re_new", 'hFF43);

    // Full checkerboard frame with drawline held
    do_reset();
    drawline = 1'b1;
    cnt = 0;
    while (renderComplete !== 1'b1 && cnt < 30000) begin tick(); cnt++; end
    drawline = 1'b0;
    check("frame_cycles", cnt, 144 * 162);
    repeat (144) model_full_line();
    tick(); tick(); tick();
    check("rc_hold", renderComplete, m_rc);
    check_rows("cb_frame", 0, 143);
    check("cb_0_0", lcd[0][0], 2'd3);
    check("cb_0_1", lcd[0][1], 2'd0);
    check("cb_1_0", lcd[1][0], 2'd0);
    check("cb_143_158", lcd[143][158], 2'd0);

    // Palette inversion; renderComplete drops once a line starts
    bus_write('hFF47, 8'h1B);
    render_lines(16);
    check("rc_clear", renderComplete, m_rc);
    check_rows("pal", 0, 15);
    check("pal_0_0", lcd[0][0], 2'd0);
    check("pal_0_1", lcd[0][1], 2'd3);

    // Horizontal scroll and wrap at 256
    do_reset();
    bus_write('hFF43, 8'h01);
    render_lines(16);
    check_rows("scx1", 0, 15);
    check("scx1_0_1", lcd[0][1], 2'd3);
    check("scx1_0_0", lcd[0][0], 2'd0);
    do_reset();
    bus_write('hFF43, 8'hFF);
    render_lines(16);
    check_rows("scxff", 0, 15);
    check("scxff_0_1", lcd[0][1], 2'd3);
    check("scxff_0_0", lcd[0][0], 2'd0);

    // Palette write mid-line lands on the next pixel fetch
    do_reset();
    drawline = 1'b1;
    tick();
    drawline = 1'b0;
    repeat (80) tick();
    bus.addr = 16'hFF47; bus.wdata = 8'h1B; bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    repeat (80) tick();
    tick();
    m_rc = 1'b0;
    model_pixels(0, 80);
    model_write('hFF47, 8'h1B);
    model_pixels(81, 159);
    model_end_line();
    check_span("midwr", 0, 0, 159);
    check("midwr_80", lcd[0][80], 2'd3);
    check("midwr_81", lcd[0][81], 2'd3);
    check("midwr_82", lcd[0][82], 2'd0);

    // Bus-written tile 1 placed at map (0,0)
    do_reset();
    for (int i = 0; i < 16; i++) bus_write('h8000 + i, 8'h00);
    bus_write('h8010, 8'h80);
    bus_write('h8011, 8'h80);
    bus_write('h9800, 8'h01);
    render_lines(16);
    check_rows("buswr", 0, 15);
    check("buswr_0_0", lcd[0][0], 2'd3);
    check("buswr_0_1", lcd[0][1], 2'd0);
    check("buswr_0_8", lcd[0][8], 2'd0);

    // Randomized scenes
    for (int round = 0; round < 2; round++) begin
      do_reset();
      for (int i = 0; i < 128; i++) bus_write('h8000 + i, 8'($urandom));
      for (int i = 0; i < 1024; i++) bus_write('h9800 + i, 8'($urandom_range(0, 7)));
      bus_write('hFF42, 8'($urandom));
      bus_write('hFF43, 8'($urandom));
      bus_write('hFF47, 8'($urandom));
      render_lines(16);
      check_rows("rand", 0, 15);
    end

    // Reset in the middle of line 10
    do_reset();
    drawline = 1'b1;
    repeat (10 * 162 + 1 + 50) tick();
    reset_n = 1'b0; drawline = 1'b0;
    tick();
    repeat (10) model_full_line();
    model_pixels(0, 49);
    check("midrst_rc", renderComplete, 1'b0);
    reset_n = 1'b1;
    m_scx = 8'h00; m_scy = 8'h00; m_bgp = 8'hE4; m_line = 0; m_rc = 1'b0;
    check_rows("midrst_done", 0, 9);
    check_span("midrst_row10", 10, 0, 159);
    bus_write('hFF47, 8'h1B);
    render_lines(1);
    check_span("restart_row0", 0, 0, 159);
    check_span("restart_row1", 1, 0, 159);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
